// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/bubble constants, next-PC select
// encoding, the IF/ID payload layout and the sequential PC increment.
package fetch_stage_pkg;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0] PC_RESET = 32'h0000_0000;

   typedef enum logic [2:0] {
      NPC_SEQ,
      NPC_HOLD,
      NPC_BR,
      NPC_MRET,
      NPC_TRAP
   } npc_sel_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic        valid;
      logic        misalign;
   } if_id_t;

   // Sequential successor; wraps naturally at 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > hold > load priority.
// A flush or reset leaves a bubble (NOP, not valid, zero PCs).
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INST = INST_NOP
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_flush,
   input  logic   i_stall,
   input  if_id_t i_d,
   output if_id_t o_q
);

   localparam if_id_t BUBBLE = '{pc: 32'h0, pc4: 32'h0, inst: NOP_INST,
                                 valid: 1'b0, misalign: 1'b0};

   if_id_t r_q;

   // Stage register: bubble on reset/flush, hold on stall, else capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= BUBBLE;
      end else if (i_flush) begin
         r_q <= BUBBLE;
      end else if (!i_stall) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, prioritised next-PC selection
// (trap > mret > branch > stall > sequential) and the IF/ID register.
// Misaligned fetch addresses are flagged and replaced by a NOP.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_RESET,
   parameter logic [31:0] NOP_INST = INST_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        trap_valid,
   input  logic [31:0] trap_target,
   input  logic        mret_valid,
   input  logic [31:0] mret_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_misalign
);

   logic [31:0] r_pc;
   logic [31:0] w_pc4;
   logic [31:0] w_pc_next;
   logic        w_redirect;
   logic        w_misalign;
   npc_sel_e    w_sel;
   if_id_t      w_if_d;
   if_id_t      w_id_q;

   assign w_pc4      = pc_inc(r_pc);
   assign w_redirect = trap_valid | mret_valid | br_taken;
   assign w_misalign = (r_pc[1:0] != 2'b00);

   // Next-PC source; any redirect outranks the load-use stall.
   always_comb begin
      w_sel = NPC_SEQ;
      if (trap_valid) begin
         w_sel = NPC_TRAP;
      end else if (mret_valid) begin
         w_sel = NPC_MRET;
      end else if (br_taken) begin
         w_sel = NPC_BR;
      end else if (stall) begin
         w_sel = NPC_HOLD;
      end
   end

   // Next-PC mux driven by the selected source.
   always_comb begin
      w_pc_next = w_pc4;
      unique case (w_sel)
         NPC_TRAP: w_pc_next = trap_target;
         NPC_MRET: w_pc_next = mret_target;
         NPC_BR:   w_pc_next = br_target;
         NPC_HOLD: w_pc_next = r_pc;
         default:  w_pc_next = w_pc4;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // A misaligned fetch never forwards the raw memory word.
   assign w_if_d = '{pc:       r_pc,
                     pc4:      w_pc4,
                     inst:     (w_misalign ? NOP_INST : imem_rdata),
                     valid:    1'b1,
                     misalign: w_misalign};

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_redirect),
      .i_stall (stall),
      .i_d     (w_if_d),
      .o_q     (w_id_q)
   );

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign id_pc       = w_id_q.pc;
   assign id_pc4      = w_id_q.pc4;
   assign id_inst     = w_id_q.inst;
   assign id_valid    = w_id_q.valid;
   assign id_misalign = w_id_q.misalign;

endmodule
